// File: rtl/forward_pkg.sv
// Shared types for the EX-stage forwarding / hazard controller: select codes,
// FSM states and the in-flight instruction tracking entries.
package forward_pkg;

    localparam int unsigned REG_IDX_W   = 5;
    localparam int unsigned SEL_W       = 2;
    localparam int unsigned STALL_CNT_W = 32;

    localparam logic [SEL_W-1:0] FWD_RF    = 2'b00;
    localparam logic [SEL_W-1:0] FWD_EXMEM = 2'b01;
    localparam logic [SEL_W-1:0] FWD_MEMWB = 2'b10;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        LDSTALL = 2'd1,
        HOLD    = 2'd2
    } fsm_state_t;

    typedef struct packed {
        logic                 valid;
        logic [REG_IDX_W-1:0] rd;
        logic                 reg_write;
        logic                 mem_read;
    } trk_t;

    typedef struct packed {
        trk_t                 trk;
        logic [REG_IDX_W-1:0] rs1;
        logic [REG_IDX_W-1:0] rs2;
    } ex_trk_t;

    // True when entry t will write architectural register idx (x0 never counts).
    function automatic logic writes_reg(input trk_t t, input logic [REG_IDX_W-1:0] idx);
        return t.valid && t.reg_write && (t.rd != '0) && (t.rd == idx);
    endfunction

endpackage

// File: rtl/forward_match.sv
// Per-operand forwarding select: the youngest in-flight writer of i_src wins.
module forward_match
    import forward_pkg::*;
(
    input  logic [REG_IDX_W-1:0] i_src,
    input  trk_t                 i_mem,
    input  trk_t                 i_wb,
    output logic [SEL_W-1:0]     o_sel_c
);

    logic w_unused;
    assign w_unused = ^{i_mem.mem_read, i_wb.mem_read};

    always_comb begin
        o_sel_c = FWD_RF;
        if (writes_reg(i_mem, i_src)) begin
            o_sel_c = FWD_EXMEM;
        end else if (writes_reg(i_wb, i_src)) begin
            o_sel_c = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/forward_ctrl.sv
// Forwarding and load-use / memory-wait hazard control for a 5-stage pipeline.
// Optional FORWARD_CTRL_STALL_CNT_EN adds a saturating stall-cycle counter.
module forward_ctrl
    import forward_pkg::*;
#(
    parameter int unsigned XLEN_REGS = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [$clog2(XLEN_REGS)-1:0] id_rs1,
    input  logic [$clog2(XLEN_REGS)-1:0] id_rs2,
    input  logic [$clog2(XLEN_REGS)-1:0] id_rd,
    input  logic                         id_valid,
    input  logic                         id_reg_write,
    input  logic                         id_mem_read,
    input  logic                         flush,
    input  logic                         mem_wait,
    output logic [SEL_W-1:0]             fwd_a_sel,
    output logic [SEL_W-1:0]             fwd_b_sel,
    output logic                         stall,
    output logic                         ex_bubble
`ifdef FORWARD_CTRL_STALL_CNT_EN
    ,
    output logic [STALL_CNT_W-1:0]       stall_cnt
`endif
);

    fsm_state_t r_state;
    fsm_state_t w_state_nxt;
    ex_trk_t    r_ex;
    ex_trk_t    w_ex_nxt;
    ex_trk_t    w_id_entry;
    trk_t       r_mem;
    trk_t       r_wb;
    logic       w_load_use;
    logic       w_stall;
    logic       w_bubble;
    logic       w_advance;

    always_comb begin
        w_id_entry               = '0;
        w_id_entry.trk.valid     = id_valid;
        w_id_entry.trk.rd        = REG_IDX_W'(id_rd);
        w_id_entry.trk.reg_write = id_reg_write;
        w_id_entry.trk.mem_read  = id_mem_read;
        w_id_entry.rs1           = REG_IDX_W'(id_rs1);
        w_id_entry.rs2           = REG_IDX_W'(id_rs2);
    end

    assign w_load_use = r_ex.trk.valid && r_ex.trk.mem_read && (r_ex.trk.rd != '0) && id_valid
                     && ((r_ex.trk.rd == REG_IDX_W'(id_rs1)) || (r_ex.trk.rd == REG_IDX_W'(id_rs2)));

    // Next state and stall decisions; mem_wait dominates flush, flush dominates load-use.
    always_comb begin
        w_state_nxt = r_state;
        w_stall     = 1'b0;
        w_bubble    = 1'b0;
        w_advance   = 1'b1;
        w_ex_nxt    = w_id_entry;
        if (mem_wait) begin
            w_state_nxt = HOLD;
            w_stall     = 1'b1;
            w_advance   = 1'b0;
            w_ex_nxt    = r_ex;
        end else if (flush) begin
            w_state_nxt = RUN;
            w_ex_nxt    = '0;
        end else begin
            case (r_state)
                RUN, HOLD: begin
                    w_state_nxt = RUN;
                    if (w_load_use) begin
                        w_state_nxt = LDSTALL;
                        w_stall     = 1'b1;
                        w_bubble    = 1'b1;
                        w_ex_nxt    = '0;
                    end
                end
                default: w_state_nxt = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RUN;
            r_ex    <= '0;
            r_mem   <= '0;
            r_wb    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ex    <= w_ex_nxt;
            if (w_advance) begin
                r_mem <= r_ex.trk;
                r_wb  <= r_mem;
            end
        end
    end

    // Stall reacts to the same-cycle ID operands, so it cannot be registered.
    assign stall     = rst_n & w_stall;
    assign ex_bubble = rst_n & w_bubble;

    forward_match u_match_a (
        .i_src   (r_ex.rs1),
        .i_mem   (r_mem),
        .i_wb    (r_wb),
        .o_sel_c (fwd_a_sel)
    );

    forward_match u_match_b (
        .i_src   (r_ex.rs2),
        .i_mem   (r_mem),
        .i_wb    (r_wb),
        .o_sel_c (fwd_b_sel)
    );

`ifdef FORWARD_CTRL_STALL_CNT_EN
    logic [STALL_CNT_W-1:0] r_stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_forward_ctrl.sv
// Bench for forward_ctrl: directed pipeline sequences plus randomized traffic
// checked against an in-flight instruction list model.
module tb_forward_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       id_valid, id_reg_write, id_mem_read, flush, mem_wait;
    logic [1:0] fwd_a_sel, fwd_b_sel;
    logic       stall, ex_bubble;
`ifdef FORWARD_CTRL_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    always #5 clk = ~clk;

    forward_ctrl #(.XLEN_REGS(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_rd        (id_rd),
        .id_valid     (id_valid),
        .id_reg_write (id_reg_write),
        .id_mem_read  (id_mem_read),
        .flush        (flush),
        .mem_wait     (mem_wait),
        .fwd_a_sel    (fwd_a_sel),
        .fwd_b_sel    (fwd_b_sel),
        .stall        (stall),
        .ex_bubble    (ex_bubble)
`ifdef FORWARD_CTRL_STALL_CNT_EN
        ,
        .stall_cnt    (stall_cnt)
`endif
    );

    typedef struct {
        logic       v;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       rw;
        logic       mr;
    } ins_t;

    typedef struct {
        ins_t       id;
        logic       fl;
        logic       mw;
        logic [1:0] ea;
        logic [1:0] eb;
        logic       es;
        logic       ebub;
    } vec_t;

    int n_checks = 0;
    int n_errors = 0;

    // Model: instructions in flight, index 0 = EX, 1 = MEM, 2 = WB.
    ins_t m_pipe[3];

    function automatic ins_t mk(logic v, int rd, int rs1, int rs2, logic rw, logic mr);
        ins_t t;
        t.v = v; t.rd = 5'(rd); t.rs1 = 5'(rs1); t.rs2 = 5'(rs2); t.rw = rw; t.mr = mr;
        return t;
    endfunction

    function automatic vec_t mkv(ins_t id, logic fl, logic mw, logic [1:0] ea, logic [1:0] eb,
                                 logic es, logic ebub);
        vec_t r;
        r.id = id; r.fl = fl; r.mw = mw; r.ea = ea; r.eb = eb; r.es = es; r.ebub = ebub;
        return r;
    endfunction

    function automatic void m_reset();
        for (int i = 0; i < 3; i++) m_pipe[i] = mk(0, 0, 0, 0, 0, 0);
    endfunction

    // Operand value comes from the youngest older instruction that writes it.
    function automatic logic [1:0] m_sel(logic [4:0] src);
        for (int age = 1; age < 3; age++) begin
            if (src != 0 && m_pipe[age].v && m_pipe[age].rw && m_pipe[age].rd == src)
                return (age == 1) ? 2'b01 : 2'b10;
        end
        return 2'b00;
    endfunction

    function automatic logic m_hazard(ins_t id, logic fl, logic mw);
        return !mw && !fl && m_pipe[0].v && m_pipe[0].mr && m_pipe[0].rd != 0 && id.v
            && (m_pipe[0].rd == id.rs1 || m_pipe[0].rd == id.rs2);
    endfunction

    function automatic void m_update(ins_t id, logic fl, logic mw);
        logic hz;
        hz = m_hazard(id, fl, mw);
        if (!mw) begin
            m_pipe[2] = m_pipe[1];
            m_pipe[1] = m_pipe[0];
            m_pipe[0] = (fl || hz) ? mk(0, 0, 0, 0, 0, 0) : id;
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // One pipeline cycle: drive ID, compare before the edge, advance the model, take the edge.
    task automatic apply(input ins_t id, input logic fl, input logic mw, input logic [1:0] ea,
                         input logic [1:0] eb, input logic es, input logic ebub,
                         input string tag, input int idx);
        id_valid = id.v; id_rd = id.rd; id_rs1 = id.rs1; id_rs2 = id.rs2;
        id_reg_write = id.rw; id_mem_read = id.mr; flush = fl; mem_wait = mw;
        #2;
        chk($sformatf("%s[%0d].fwd_a_sel", tag, idx), 32'(fwd_a_sel), 32'(ea));
        chk($sformatf("%s[%0d].fwd_b_sel", tag, idx), 32'(fwd_b_sel), 32'(eb));
        chk($sformatf("%s[%0d].stall", tag, idx), 32'(stall), 32'(es));
        chk($sformatf("%s[%0d].ex_bubble", tag, idx), 32'(ex_bubble), 32'(ebub));
        m_update(id, fl, mw);
        @(posedge clk);
        #1;
    endtask

    task automatic apply_model(input ins_t id, input logic fl, input logic mw,
                               input string tag, input int idx);
        logic hz;
        hz = m_hazard(id, fl, mw);
        apply(id, fl, mw, m_sel(m_pipe[0].rs1), m_sel(m_pipe[0].rs2), mw | hz, hz, tag, idx);
    endtask

    vec_t tab[$];

    initial begin
        ins_t nop, add5a, sub6, or7, add5b, sub10, lw8, add9, add0, use0, lw0, use03, add_f, add88;
        nop   = mk(0, 0, 0, 0, 0, 0);
        add5a = mk(1, 5, 1, 2, 1, 0);
        sub6  = mk(1, 6, 5, 1, 1, 0);
        or7   = mk(1, 7, 1, 5, 1, 0);
        add5b = mk(1, 5, 3, 4, 1, 0);
        sub10 = mk(1, 10, 5, 5, 1, 0);
        lw8   = mk(1, 8, 2, 0, 1, 1);
        add9  = mk(1, 9, 8, 8, 1, 0);
        add0  = mk(1, 0, 1, 2, 1, 0);
        use0  = mk(1, 11, 0, 0, 1, 0);
        lw0   = mk(1, 0, 2, 0, 1, 1);
        use03 = mk(1, 12, 0, 3, 1, 0);
        add_f = mk(1, 13, 8, 1, 1, 0);
        add88 = mk(1, 14, 8, 8, 1, 0);

        // add x5 ; sub x6,x5,x1 -> EX/MEM on operand A
        tab.push_back(mkv(add5a, 0, 0, 2'b00, 2'b00, 0, 0));
        tab.push_back(mkv(sub6,  0, 0, 2'b00, 2'b00, 0, 0));
        tab.push_back(mkv(nop,   0, 0, 2'b01, 2'b00, 0, 0));
        tab.push_back(mkv(nop,   0, 0, 2'b00, 2'b00, 0, 0));
        // add x5 ; nop ; or x7,x1,x5 -> MEM/WB on operand B
        tab.push_back(mkv(add5a, 0, 0, 2'b00, 2'b00, 0, 0));
        tab.push_back(mkv(nop,   0, 0, 2'b00, 2'b00, 0, 0));
        tab.push_back(mkv(or7,   0, 0, 2'b00, 2'b00, 0, 0));
        tab.push_back(mkv(nop,   0, 0, 2'b00, 2'b10, 0, 0));
        // two writers of x5 -> MEM wins
        tab.push_back(mkv(add5a, 0, 0, 2'b00, 2'b00, 0, 0));
        tab.push_back(mkv(add5b, 0, 0, 2'b00, 2'b00, 0, 0));
        tab.push_back(mkv(sub10, 0, 0, 2'b00, 2'b00, 0, 0));
        tab.push_back(mkv(nop,   0, 0, 2'b01, 2'b01, 0, 0));
        // lw x8 ; add x9,x8,x8 -> one bubble, then MEM/WB on both
        tab.push_back(mkv(lw8,   0, 0, 2'b00, 2'b00, 0, 0));
        tab.push_back(mkv(add9,  0, 0, 2'b00, 2'b00, 1, 1));
        tab.push_back(mkv(add9,  0, 0, 2'b00, 2'b00, 0, 0));
        tab.push_back(mkv(nop,   0, 0, 2'b10, 2'b10, 0, 0));
        // x0 writes are never forwarded, loads to x0 never stall
        tab.push_back(mkv(add0,  0, 0, 2'b00, 2'b00, 0, 0));
        tab.push_back(mkv(use0,  0, 0, 2'b00, 2'b00, 0, 0));
        tab.push_back(mkv(nop,   0, 0, 2'b00, 2'b00, 0, 0));
        tab.push_back(mkv(lw0,   0, 0, 2'b00, 2'b00, 0, 0));
        tab.push_back(mkv(use03, 0, 0, 2'b00, 2'b00, 0, 0));
        tab.push_back(mkv(nop,   0, 0, 2'b00, 2'b00, 0, 0));
        // load-use with flush, then a 3-cycle memory wait with frozen selects
        tab.push_back(mkv(lw8,   0, 0, 2'b00, 2'b00, 0, 0));
        tab.push_back(mkv(add_f, 1, 0, 2'b00, 2'b00, 0, 0));
        tab.push_back(mkv(add88, 0, 0, 2'b00, 2'b00, 0, 0));
        tab.push_back(mkv(nop,   0, 1, 2'b10, 2'b10, 1, 0));
        tab.push_back(mkv(nop,   0, 1, 2'b10, 2'b10, 1, 0));
        tab.push_back(mkv(nop,   0, 1, 2'b10, 2'b10, 1, 0));
        tab.push_back(mkv(nop,   0, 0, 2'b10, 2'b10, 0, 0));
        tab.push_back(mkv(nop,   0, 0, 2'b00, 2'b00, 0, 0));
        // load-use arriving during a memory wait is re-evaluated on release
        tab.push_back(mkv(lw8,   0, 0, 2'b00, 2'b00, 0, 0));
        tab.push_back(mkv(add88, 0, 1, 2'b00, 2'b00, 1, 0));
        tab.push_back(mkv(add88, 0, 1, 2'b00, 2'b00, 1, 0));
        tab.push_back(mkv(add88, 0, 0, 2'b00, 2'b00, 1, 1));
        tab.push_back(mkv(add88, 0, 0, 2'b00, 2'b00, 0, 0));
        tab.push_back(mkv(nop,   0, 1, 2'b10, 2'b10, 1, 0));

        // Reset asserted with hostile inputs: every output must read zero.
        rst_n = 1'b0;
        id_valid = 1'b1; id_rd = 5'd8; id_rs1 = 5'd8; id_rs2 = 5'd8;
        id_reg_write = 1'b1; id_mem_read = 1'b1; flush = 1'b0; mem_wait = 1'b1;
        m_reset();
        #12;
        chk("reset.fwd_a_sel", 32'(fwd_a_sel), 32'd0);
        chk("reset.fwd_b_sel", 32'(fwd_b_sel), 32'd0);
        chk("reset.stall", 32'(stall), 32'd0);
        chk("reset.ex_bubble", 32'(ex_bubble), 32'd0);
        #8;
        rst_n = 1'b1;

        foreach (tab[i]) begin
            apply(tab[i].id, tab[i].fl, tab[i].mw, tab[i].ea, tab[i].eb, tab[i].es, tab[i].ebub,
                  "dir", i);
        end

        // Reset pulse in the middle of a hold with live forwarding.
        #1;
        rst_n = 1'b0;
        #1;
        chk("rstpulse.fwd_a_sel", 32'(fwd_a_sel), 32'd0);
        chk("rstpulse.fwd_b_sel", 32'(fwd_b_sel), 32'd0);
        chk("rstpulse.stall", 32'(stall), 32'd0);
        chk("rstpulse.ex_bubble", 32'(ex_bubble), 32'd0);
        #1;
        rst_n = 1'b1;
        mem_wait = 1'b0;
        id_valid = 1'b0;
        #1;
        chk("postrst.stall", 32'(stall), 32'd0);
        chk("postrst.fwd_a_sel", 32'(fwd_a_sel), 32'd0);
        m_reset();
        apply_model(lw8, 0, 0, "postrst", 0);
        apply_model(add9, 0, 0, "postrst", 1);
        chk("postrst.first_edge_load_stalls", 32'(m_pipe[0].v), 32'd0);
        apply_model(add9, 0, 0, "postrst", 2);
        apply_model(nop, 0, 0, "postrst", 3);

        // Random traffic on a small register set to force frequent collisions.
        for (int n = 0; n < 3000; n++) begin
            ins_t r;
            logic rfl, rmw;
            r   = mk($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
                     $urandom_range(0, 3), $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
            rfl = ($urandom_range(0, 7) == 0);
            rmw = ($urandom_range(0, 5) == 0);
            apply_model(r, rfl, rmw, "rnd", n);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
